uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 145 ++++++++++++++
 tb/tb_uart_word_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises 32-bit words as four contiguous 8N1 UART bytes,
// least significant byte first, bits within each byte LSB first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // The last stop bit of a word spends one cycle less in STOP: its final
    // cycle is the IDLE cycle in which the next word may be accepted. The
    // line still sees a full-length stop bit, and a queued word starts its
    // start bit immediately afterwards with no idle gap.
    localparam logic [CNT_W-1:0] CNT_LAST_STOP = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      shift_q, shift_d;
    logic             tx_q, tx_d;

    logic accept;
    logic bit_end;

    assign in_ready_o = (state_q == IDLE) && !rst_i;
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = (state_q != IDLE);
    assign tx_o       = tx_q;
    assign bit_end    = (cnt_q == CNT_LAST);

    // Next-state, bit timing and serial line level for the following cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = START;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    shift_d    = in_data_i;
                    tx_d       = 1'b0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (byte_idx_q == 2'd3) begin
                    if (cnt_q == CNT_LAST_STOP) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        byte_idx_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (bit_end) begin
                    state_d    = START;
                    cnt_d      = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    tx_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Control state register; reset aborts any word in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
        end
    end

    // Word shift register; contents are only meaningful after an acceptance.
    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx with CLKS_PER_BIT = 4: a per-cycle line-level model,
// a UART receiver decoding captured samples, table vectors and directed
// sequences for reset, back-to-back and streaming cases.
module tb_uart_word_tx;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx;
    logic        busy;

    uart_word_tx #(.CLKS_PER_BIT(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .tx_o       (tx),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    bit   chk_en = 1'b0;
    bit   cap_en = 1'b0;
    bit   capq[$];
    bit   mq[$];
    bit   m_rdy;
    int   dut_acc = 0;
    logic [7:0] rx_bytes[$];
    int   rx_starts[$];

    typedef struct {
        logic [31:0] word;
        logic [9:0]  first_frame;
        logic [9:0]  last_frame;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: each accepted word becomes 40 line levels (start, 8 data
    // bits LSB first, stop per byte), each held for N cycles. The word
    // occupies the N*40 cycles after its acceptance edge and the next word
    // can be accepted on the edge that ends the last of those cycles.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_rdy = (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_rdy && in_valid) begin
                for (int k = 0; k < 4; k++) begin
                    for (int j = 0; j < 10; j++) begin
                        for (int r = 0; r < N; r++) begin
                            if (j == 0)      mq.push_back(1'b0);
                            else if (j == 9) mq.push_back(1'b1);
                            else             mq.push_back(in_data[8*k + j - 1]);
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_level", tx, (mq.size() > 0) ? mq[0] : 1'b1);
            check("busy", busy, mq.size() >= 2);
            check("in_ready", in_ready, !rst && (mq.size() <= 1));
        end
        if (cap_en) capq.push_back(tx);
        if (in_valid && in_ready) dut_acc++;
    end

    // UART receiver: find falling edges, sample each bit at its centre.
    task automatic decode();
        int i;
        logic [7:0] b;
        rx_bytes.delete();
        rx_starts.delete();
        i = 1;
        while (i + 10*N <= capq.size()) begin
            if (capq[i] == 1'b0 && capq[i-1] == 1'b1) begin
                for (int k = 0; k < 8; k++) b[k] = capq[i + N*(k+1) + N/2];
                rx_bytes.push_back(b);
                rx_starts.push_back(i);
                i = i + 9*N + N/2;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [31:0] rx_word(input int k);
        return {rx_bytes[4*k+3], rx_bytes[4*k+2], rx_bytes[4*k+1], rx_bytes[4*k]};
    endfunction

    function automatic logic [9:0] frame_at(input int s);
        logic [9:0] f;
        for (int j = 0; j < 10; j++) f[j] = capq[s + N*j + N/2];
        return f;
    endfunction

    task automatic run_word(input logic [31:0] w);
        capq.delete();
        cap_en   = 1'b1;
        in_valid = 1'b1;
        in_data  = w;
        cyc();
        in_valid = 1'b0;
        in_data  = $urandom();
        repeat (165) cyc();
        cap_en = 1'b0;
        decode();
    endtask

    logic [31:0] dv[320];
    logic [31:0] src[$];
    logic [31:0] sent[$];
    int acc0;
    int guard;
    bit acc;

    initial begin
        vt[0] = '{32'h44332211, 10'h222, 10'h288};
        vt[1] = '{32'hA5A5A5A5, 10'h34A, 10'h34A};
        vt[2] = '{32'h12345678, 10'h2F0, 10'h224};
        vt[3] = '{32'h80000001, 10'h202, 10'h300};
        vt[4] = '{32'hFFFFFFFF, 10'h3FE, 10'h3FE};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        cyc();
        chk_en = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1'b1);
        cyc();

        // Table vectors: single words sent from idle.
        for (int v = 0; v < 5; v++) begin
            run_word(vt[v].word);
            check("vec_nbytes", rx_bytes.size(), 4);
            if (rx_bytes.size() >= 4) begin
                check("vec_latency", rx_starts[0], 1);
                check("vec_first_frame", frame_at(rx_starts[0]), vt[v].first_frame);
                check("vec_last_frame", frame_at(rx_starts[3]), vt[v].last_frame);
                check("vec_word", rx_word(0), vt[v].word);
                check("vec_contiguous", rx_starts[3] - rx_starts[0], 30*N);
            end
        end

        // Back-to-back words with valid held high.
        acc0 = dut_acc;
        capq.delete();
        cap_en   = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        cyc();
        in_data = 32'h00000000;
        repeat (160) cyc();
        in_valid = 1'b0;
        repeat (170) cyc();
        cap_en = 1'b0;
        decode();
        check("b2b_acc", dut_acc - acc0, 2);
        check("b2b_nbytes", rx_bytes.size(), 8);
        if (rx_bytes.size() >= 8) begin
            check("b2b_second_start", rx_starts[4] - rx_starts[0], 40*N);
            check("b2b_last_start", rx_starts[7], 1 + 70*N);
            check("b2b_word0", rx_word(0), 32'hFFFFFFFF);
            check("b2b_word1", rx_word(1), 32'h00000000);
        end

        // Reset in the middle of a word, then a fresh word.
        in_valid = 1'b1;
        in_data  = 32'h0F0F1234;
        cyc();
        in_valid = 1'b0;
        repeat (49) cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        run_word(32'hA5A5A5A5);
        check("after_rst_nbytes", rx_bytes.size(), 4);
        if (rx_bytes.size() >= 4) begin
            check("after_rst_word", rx_word(0), 32'hA5A5A5A5);
            check("after_rst_frame", frame_at(rx_starts[0]), 10'h34A);
        end

        // Reset and valid together: nothing may be accepted.
        acc0 = dut_acc;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("rstvld_acc", dut_acc - acc0, 0);
        check("rstvld_tx", tx, 1'b1);
        check("rstvld_busy", busy, 1'b0);
        cyc();

        // Valid held with data changing every cycle.
        acc0 = dut_acc;
        capq.delete();
        cap_en   = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 320; k++) begin
            in_data = (k == 0) ? 32'hC3C3_5A5A : $urandom();
            dv[k]   = in_data;
            cyc();
        end
        in_valid = 1'b0;
        repeat (170) cyc();
        cap_en = 1'b0;
        decode();
        check("hold_acc", dut_acc - acc0, 2);
        check("hold_nbytes", rx_bytes.size(), 8);
        if (rx_bytes.size() >= 8) begin
            check("hold_word0", rx_word(0), dv[0]);
            check("hold_word1", rx_word(1), dv[160]);
        end

        // Stream of 16 random words from an upstream FIFO with random bubbles.
        src.delete();
        sent.delete();
        for (int k = 0; k < 16; k++) begin
            src.push_back($urandom());
            sent.push_back(src[k]);
        end
        capq.delete();
        cap_en = 1'b1;
        guard  = 0;
        while (src.size() > 0 && guard < 6000) begin
            if ($urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = src[0];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom();
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            cyc();
            if (acc) void'(src.pop_front());
            guard++;
        end
        in_valid = 1'b0;
        check("stream_drained", src.size(), 0);
        repeat (200) cyc();
        cap_en = 1'b0;
        decode();
        check("stream_nbytes", rx_bytes.size(), 64);
        for (int k = 0; k < 16; k++) begin
            if (rx_bytes.size() >= 4*(k+1)) check("stream_word", rx_word(k), sent[k]);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
